// File: rtl/mem_arbiter_if.sv
// Signal bundle shared by the two cache controllers, the memory arbiter and
// the four-banked main memory. The arbiter uses the slave view; the
// requesters and the memory model together use the master view.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    // Requester side
    logic [1:0]        req_rd;
    logic [1:0]        req_wr;
    logic [ADDR_W-1:0] req_addr0;
    logic [ADDR_W-1:0] req_addr1;
    logic [DATA_W-1:0] req_wdata0;
    logic [DATA_W-1:0] req_wdata1;
    logic [1:0]        gnt;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        err;

    // Memory side
    logic [3:0]        busy;
    logic              mem_rd;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport slave (
        input  req_rd, req_wr, req_addr0, req_addr1, req_wdata0, req_wdata1,
        input  busy, mem_data_out,
        output gnt, rvalid, rdata, err,
        output mem_rd, mem_wr, mem_addr, mem_data_in
    );

    modport master (
        output req_rd, req_wr, req_addr0, req_addr1, req_wdata0, req_wdata1,
        output busy, mem_data_out,
        input  gnt, rvalid, rdata, err,
        input  mem_rd, mem_wr, mem_addr, mem_data_in
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a four-banked main memory.
// Requester 0 is the instruction cache, requester 1 the data cache. Each
// cycle at most one legal request whose bank is idle is granted and drives
// the memory port combinationally; ties alternate via rr_last. Accepted
// reads are tagged in a shift pipe so returned data is steered back to its
// owner RD_LAT cycles later.
module mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 2
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    logic [1:0]        legal;
    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              win_id;
    logic              win_rd;
    logic [ADDR_W-1:0] win_addr;
    logic [DATA_W-1:0] win_data;
    logic              rr_last;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [RD_LAT-1:0] pipe_vld;
    logic [RD_LAT-1:0] pipe_id;
    logic              ret_vld;

    // Legality, bank availability and round-robin selection of one winner.
    // Grants are suppressed while reset is held so no strobe escapes during reset.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        legal       = bus.req_rd ^ bus.req_wr;
        eligible[0] = legal[0] & ~bus.busy[bus.req_addr0[2:1]];
        eligible[1] = legal[1] & ~bus.busy[bus.req_addr1[2:1]];
        grant       = 2'b00;
        win_id      = 1'b0;
        if (!rst) begin
            if (eligible[0] && eligible[1]) begin
                win_id = ~rr_last;
                grant  = win_id ? 2'b10 : 2'b01;
            end else if (eligible[0]) begin
                win_id = 1'b0;
                grant  = 2'b01;
            end else if (eligible[1]) begin
                win_id = 1'b1;
                grant  = 2'b10;
            end
        end
        win_rd   = win_id ? bus.req_rd[1]     : bus.req_rd[0];
        win_addr = win_id ? bus.req_addr1     : bus.req_addr0;
        win_data = win_id ? bus.req_wdata1    : bus.req_wdata0;
    end

    // Memory port and requester-facing outputs; address/data hold when idle.
    always_comb begin
        ret_vld         = pipe_vld[RD_LAT-1] & ~rst;
        bus.gnt         = grant;
        bus.err         = rst ? 2'b00 : (bus.req_rd & bus.req_wr);
        bus.mem_rd      = (|grant) & win_rd;
        bus.mem_wr      = (|grant) & ~win_rd;
        bus.mem_addr    = (|grant) ? win_addr : addr_q;
        bus.mem_data_in = (|grant) ? win_data : data_q;
        bus.rvalid      = 2'b00;
        bus.rdata       = '0;
        if (ret_vld) begin
            bus.rvalid = pipe_id[RD_LAT-1] ? 2'b10 : 2'b01;
            bus.rdata  = bus.mem_data_out;
        end
    end

    // Round-robin pointer and the last address/data driven to memory.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            rr_last <= 1'b1;
            addr_q  <= '0;
            data_q  <= '0;
        end else if (|grant) begin
            rr_last <= win_id;
            addr_q  <= win_addr;
            data_q  <= win_data;
        end
    end

    // Read-tag pipe: stage 0 takes the accepted read, the last stage returns it.
    always_ff @(posedge clk) begin
        // NOTE: the valid bits must be cleared so in-flight reads are dropped; ids are cleared too for a clean state.
        if (rst) begin
            pipe_vld <= '0;
            pipe_id  <= '0;
        end else begin
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_vld[i] <= pipe_vld[i-1];
                pipe_id[i]  <= pipe_id[i-1];
            end
            pipe_vld[0] <= (|grant) & win_rd;
            pipe_id[0]  <= win_id;
        end
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single four-banked main memory between the instruction-cache controller (requester 0) and the data-cache controller (requester 1).
- Each cycle it selects at most one legal request whose target bank is idle, drives the memory port, and tags the read so the returned data is routed to its owner.
- It sits between the two cache controllers' mem_rd/mem_wr outputs and the memory module.

Parameters:
ADDR_W, 16, address width
DATA_W, 16, data width
RD_LAT, 2, cycles from an accepted read to valid data on mem_data_out (minimum 1)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
req_rd  in  2  per-requester read request, level-held until granted ([0]=I, [1]=D)
req_wr  in  2  per-requester write request, level-held until granted
req_addr0  in  ADDR_W  requester 0 address
req_addr1  in  ADDR_W  requester 1 address
req_wdata0  in  DATA_W  requester 0 write data
req_wdata1  in  DATA_W  requester 1 write data
gnt  out  2  one-hot; request accepted this cycle
rvalid  out  2  one-cycle pulse; read data for that requester is on rdata
rdata  out  DATA_W  returned read data, shared by both requesters
err  out  2  illegal request (rd and wr both high)
busy  in  4  per-bank busy from memory; bank = addr[2:1]
mem_rd  out  1  memory read strobe
mem_wr  out  1  memory write strobe
mem_addr  out  ADDR_W  muxed address
mem_data_in  out  DATA_W  muxed write data
mem_data_out  in  DATA_W  memory read data

Behaviour:
- Reset values: gnt=0, rvalid=0, err=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_data_in=0, rdata=0; read-tag pipe cleared; rr_last=1.
- Legal request for requester i: req_rd[i] XOR req_wr[i].
- Illegal request (both high):
  - err[i]=1 combinationally.
  - The request is never granted and has no memory effect.
  - err[i] deasserts when the requester drops either strobe.
- Eligibility: the request is legal AND busy[addr_i[2:1]]==0.
- Arbitration (combinational, same cycle):
  - If only one requester is eligible, grant it.
  - If both are eligible, grant the requester != rr_last.
  - On each grant, rr_last <= granted id.
  - Requester 0 wins the first tie after reset.
- On grant:
  - gnt[i]=1.
  - mem_rd or mem_wr is driven in the same cycle with the granted addr and wdata.
  - The requester deasserts its request next cycle. If still asserted, it is treated as a new request.
- No grant: mem_rd=mem_wr=0; mem_addr and mem_data_in hold their last driven values.
- Write completion is the grant cycle. No later acknowledgement is issued.
- Read return uses a shift pipe of RD_LAT entries {valid,id}:
  - An accepted read enters at stage 0.
  - When the entry reaches stage RD_LAT-1's output, rvalid[id] pulses and rdata=mem_data_out in that cycle.
  - At most one issue per cycle, so at most one return per cycle; returns are in issue order.
- Reads to different idle banks issue back-to-back (one per cycle); their returns appear on consecutive cycles.
- Same-bank conflict: the loser waits while busy[bank]=1. Round-robin still applies once eligible.
- Reset mid-operation: the pipe is cleared, in-flight reads are discarded, and no rvalid is generated.
- No combinational path from rvalid to gnt. gnt depends only on req_*, busy and rr_last.

Test Plan:
- Reset then req_rd=2'b01, addr0=16'h0010, busy=0 -> gnt=01 and mem_rd=1, mem_addr=16'h0010 same cycle; 2 cycles later rvalid=01, rdata=mem_data_out.
- Both read, addr0=16'h0000, addr1=16'h0002, busy=0 -> cycle0 gnt=01, cycle1 gnt=10 (if still held); rvalid=01 at cycle2, rvalid=10 at cycle3.
- Both write the same bank (addr 16'h0004 and 16'h0024), busy[2] set for 4 cycles after the first grant -> one gnt; the other is granted only once busy[2]=0; rr_last alternates on repeated ties.
- req_rd[1]=req_wr[1]=1 -> err=10, gnt[1] never asserted, no mem strobe; drop req_wr[1] -> err=00, read is granted normally.
- Issue a read, assert rst the next cycle -> no rvalid ever appears; all outputs 0 the cycle after rst.
- Requester 0 holds a read to a busy bank while requester 1 issues to free banks -> gnt=10 each cycle until the bank frees, then requester 0 is granted on the next tie per rr_last.
